// File: rtl/seg_adder_display_if.sv
// seg_adder_display_if
// Operand/result bus between the switch/button front end and the adder.
//   a, b      : WIDTH-bit operands
//   ci        : carry-in
//   mode      : 0 = add a+b+ci, 1 = accumulate sum+b+ci
//   load      : single-cycle operation strobe
//   clr       : synchronous clear of result and flags
//   sum, cout : registered result and its carry
//   ovf       : sticky accumulate-carry flag
//   done      : one-cycle pulse after an accepted load
// master drives operands/strobes, slave (the adder) drives results.
interface seg_adder_display_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             mode;
  logic             load;
  logic             clr;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             done;

  modport master (
    output a, b, ci, mode, load, clr,
    input  sum, cout, ovf, done
  );

  modport slave (
    input  a, b, ci, mode, load, clr,
    output sum, cout, ovf, done
  );
endinterface

// File: rtl/seg_adder_display.sv
// seg_adder_display
// Registered adder/accumulator whose (WIDTH+1)-bit result {cout, sum} is
// scanned one hex digit at a time onto a common seven-segment bus.
// Ports:
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : seg_adder_display_if.slave (operands, strobes, result, flags)
//   seg   : active-high segments, bit6..bit0 = a..g
//   an    : active-low one-hot digit enable, bit i = nibble i
// Optional feature: define SEG_LZB_EN for leading-zero blanking of digits
// above digit 0.
module seg_adder_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seg_adder_display_if.slave     bus,
  output logic [6:0]             seg,
  output logic [DIGITS-1:0]      an
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    scan_cnt;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH:0]      res;
  logic [WIDTH-1:0]    opx;
  logic [4*DIGITS-1:0] disp;
  logic [3:0]          nib;
  logic [6:0]          seg_next;
`ifdef SEG_LZB_EN
  logic                blank;
`endif

  function automatic logic [6:0] hex_enc(input logic [3:0] v);
    case (v)
      4'h0: hex_enc = 7'h7E;
      4'h1: hex_enc = 7'h30;
      4'h2: hex_enc = 7'h6D;
      4'h3: hex_enc = 7'h79;
      4'h4: hex_enc = 7'h33;
      4'h5: hex_enc = 7'h5B;
      4'h6: hex_enc = 7'h5F;
      4'h7: hex_enc = 7'h70;
      4'h8: hex_enc = 7'h7F;
      4'h9: hex_enc = 7'h7B;
      4'hA: hex_enc = 7'h77;
      4'hB: hex_enc = 7'h1F;
      4'hC: hex_enc = 7'h4E;
      4'hD: hex_enc = 7'h3D;
      4'hE: hex_enc = 7'h4F;
      default: hex_enc = 7'h47;
    endcase
  endfunction

  // Accumulate mode feeds the current result back as the first operand.
  assign opx = bus.mode ? bus.sum : bus.a;
  assign res = {1'b0, opx} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.ci};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.clr) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.load) begin
      bus.sum  <= res[WIDTH-1:0];
      bus.cout <= res[WIDTH];
      if (bus.mode && res[WIDTH]) bus.ovf <= 1'b1;
      bus.done <= 1'b1;
    end else begin
      bus.done <= 1'b0;
    end
  end

  // Select the nibble for the current digit; blanking looks at this digit
  // and everything above it, so an interior zero is still shown.
  always_comb begin
    disp           = '0;
    disp[WIDTH:0]  = {bus.cout, bus.sum};
    nib            = 4'h0;
`ifdef SEG_LZB_EN
    blank          = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib = disp[i*4 +: 4];
`ifdef SEG_LZB_EN
        blank = (i != 0) && ((disp >> (4*i)) == '0);
`endif
      end
    end
`ifdef SEG_LZB_EN
    seg_next = blank ? 7'h00 : hex_enc(nib);
`else
    seg_next = hex_enc(nib);
`endif
  end

  // seg and an are registered from the same idx so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg      <= 7'h00;
      an       <= '1;
    end else begin
      seg <= seg_next;
      an  <= ~(DIGITS'(1) << idx);
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_adder_display.sv
module tb_seg_adder_display;
  localparam int W = 8;
  localparam int D = 3;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   seg;
  logic [D-1:0] an;

  seg_adder_display_if #(.WIDTH(W)) bus ();

  seg_adder_display #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: displayed value {cout,sum} as an integer, flags, and
  // number of clock edges since reset release.
  int m_val;
  int m_ovf;
  int m_done;
  int m_t;
  logic [6:0] exp_seg;
  logic [D-1:0] exp_an;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  function automatic logic [6:0] exp_digit(int v, int dig);
    int nib;
    nib = (v >> (4*dig)) & 15;
`ifdef SEG_LZB_EN
    if (dig > 0 && (v >> (4*dig)) == 0) return 7'h00;
`endif
    return seg_tab[nib];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_ovf = 0; m_done = 0; m_t = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_sum",  32'(bus.sum),  32'h0);
    check("rst_cout", 32'(bus.cout), 32'h0);
    check("rst_ovf",  32'(bus.ovf),  32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_seg",  32'(seg),      32'h00);
    check("rst_an",   32'(an),       32'h7);
  endtask

  // One clock: predict from the current inputs and model state, clock, compare.
  task automatic step();
    int dig, x, r;
    dig     = (m_t / S) % D;
    exp_an  = ~(D'(1) << dig);
    exp_seg = exp_digit(m_val, dig);
    if (bus.clr) begin
      m_val = 0; m_ovf = 0; m_done = 0;
    end else if (bus.load) begin
      x = bus.mode ? (m_val % 256) : int'(bus.a);
      r = x + int'(bus.b) + int'(bus.ci);
      m_val = r;
      if (bus.mode && r >= 256) m_ovf = 1;
      m_done = 1;
    end else begin
      m_done = 0;
    end
    m_t++;
    @(posedge clk);
    #1;
    check("sum",  32'(bus.sum),  32'(m_val % 256));
    check("cout", 32'(bus.cout), 32'(m_val / 256));
    check("ovf",  32'(bus.ovf),  32'(m_ovf));
    check("done", 32'(bus.done), 32'(m_done));
    check("an",   32'(an),       32'(exp_an));
    check("seg",  32'(seg),      32'(exp_seg));
  endtask

  task automatic idle(int n);
    bus.load = 1'b0; bus.clr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic op(logic md, logic [W-1:0] av, logic [W-1:0] bv, logic c);
    bus.mode = md; bus.a = av; bus.b = bv; bus.ci = c; bus.load = 1'b1; bus.clr = 1'b0;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.mode = 1'b0;
    bus.load = 1'b0; bus.clr = 1'b0;
    rst_n = 1'b0;
    #12;
    check_reset_vals();
    #1 rst_n = 1'b1;
    model_reset();

    // first edge after release
    idle(1);
    check("first_an",  32'(an),  32'h6);
    check("first_seg", 32'(seg), 32'h7E);

    // scan rotation over all digits and back
    idle(14);

    // add with carry
    op(1'b0, 8'hFF, 8'h01, 1'b1);
    check("add_sum",  32'(bus.sum),  32'h01);
    check("add_cout", 32'(bus.cout), 32'h1);
    check("add_done", 32'(bus.done), 32'h1);
    idle(1);
    check("add_done_low", 32'(bus.done), 32'h0);
    idle(12);

    // accumulate chain with back-to-back loads
    bus.clr = 1'b1; step(); bus.clr = 1'b0;
    op(1'b1, 8'h00, 8'h80, 1'b0);
    op(1'b1, 8'h00, 8'h80, 1'b0);
    check("acc2_sum", 32'(bus.sum), 32'h00);
    check("acc2_ovf", 32'(bus.ovf), 32'h1);
    op(1'b1, 8'h00, 8'h80, 1'b0);
    check("acc3_sum", 32'(bus.sum), 32'h80);
    check("acc3_ovf", 32'(bus.ovf), 32'h1);
    idle(2);
    bus.clr = 1'b1; step(); bus.clr = 1'b0;
    check("clr_ovf", 32'(bus.ovf), 32'h0);

    // clr wins over simultaneous load
    op(1'b0, 8'h55, 8'h22, 1'b0);
    bus.mode = 1'b0; bus.a = 8'h12; bus.b = 8'h34; bus.load = 1'b1; bus.clr = 1'b1;
    step();
    bus.load = 1'b0; bus.clr = 1'b0;
    check("clrld_sum",  32'(bus.sum),  32'h0);
    check("clrld_done", 32'(bus.done), 32'h0);
    idle(12);

    // small value and zero for blanking behaviour
    op(1'b0, 8'h02, 8'h03, 1'b0);
    idle(13);
    bus.clr = 1'b1; step(); bus.clr = 1'b0;
    idle(13);

    // async reset in the middle of a scan
    idle(5);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    #2 rst_n = 1'b1;
    model_reset();
    idle(6);

    // randomized operations
    for (int i = 0; i < 400; i++) begin
      bus.a    = W'($urandom);
      bus.b    = W'($urandom);
      bus.ci   = 1'($urandom);
      bus.mode = 1'($urandom);
      bus.load = ($urandom_range(0, 2) == 0);
      bus.clr  = ($urandom_range(0, 19) == 0);
      step();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
